// File: rtl/rtc_scan_decoder.sv
// Recovers digit values and decimal points from a multiplexed 7-segment scan
// and publishes one frame per complete set of NDIG digits; flags scan loss.
module rtc_scan_decoder #(
  parameter int NDIG       = 6,
  parameter int STABLE_CNT = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic              i_sclk,
  input  logic              i_reset_n,
  input  logic [7:0]        i_digit_sel,
  input  logic [7:0]        i_seg_pat,
  output logic [4*NDIG-1:0] o_frame,
  output logic [NDIG-1:0]   o_frame_dp,
  output logic              o_frame_valid,
  output logic              o_pat_err,
  output logic              o_sel_err,
  output logic              o_scan_lost
);

  localparam int            IW   = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    STAB = 4'(STABLE_CNT);
  localparam logic [IW-1:0] TMO  = IW'(TIMEOUT);

  typedef enum logic {COLLECT, PUBLISH} state_t;

  state_t              state_q, state_d;
  logic                in_vld_q;
  logic [7:0]          sel_q, pat_q, prev_sel_q, prev_pat_q;
  logic [3:0]          cnt_q, cnt_d;
  logic [4*NDIG-1:0]   buf_q, buf_d, frame_q, frame_d;
  logic [NDIG-1:0]     bdp_q, bdp_d, fdp_q, fdp_d, mask_q, mask_d;
  logic [IW-1:0]       idle_q, idle_d;
  logic                lost_q, lost_d, pat_err_q, pat_err_d, sel_err_q, sel_err_d;

  logic [3:0]          n_low;
  logic [2:0]          dig;
  logic                sel_ok, pair_same, accept;
  logic [3:0]          val;

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   seg_decode = 4'h0;
      7'h79:   seg_decode = 4'h1;
      7'h24:   seg_decode = 4'h2;
      7'h30:   seg_decode = 4'h3;
      7'h19:   seg_decode = 4'h4;
      7'h12:   seg_decode = 4'h5;
      7'h02:   seg_decode = 4'h6;
      7'h78:   seg_decode = 4'h7;
      7'h00:   seg_decode = 4'h8;
      7'h10:   seg_decode = 4'h9;
      7'h7F:   seg_decode = 4'hF;
      default: seg_decode = 4'hE;
    endcase
  endfunction

  always_comb begin
    n_low = '0;
    dig   = '0;
    for (int k = 0; k < 8; k++) n_low = n_low + {3'b000, ~sel_q[k]};
    for (int k = 0; k < NDIG; k++) if (!sel_q[k]) dig = 3'(k);
    sel_ok = (n_low == 4'd1) && (sel_q[NDIG-1:0] != '1);
    val    = seg_decode(pat_q[6:0]);

    // cnt_q == 0 marks "no previous sample", so the first sample after reset
    // never matches stale register contents.
    pair_same = (cnt_q != 4'd0) && (sel_q == prev_sel_q) && (pat_q == prev_pat_q);
    accept    = in_vld_q && sel_ok &&
                (pair_same ? (cnt_q == STAB - 4'd1) : (STABLE_CNT == 1));

    if (!in_vld_q)          cnt_d = 4'd0;
    else if (!pair_same)    cnt_d = 4'd1;
    else if (cnt_q == STAB) cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 4'd1;

    if (accept)             idle_d = '0;
    else if (idle_q == TMO) idle_d = idle_q;
    else                    idle_d = idle_q + 1'b1;
    lost_d = (idle_d == TMO);

    buf_d  = buf_q;
    bdp_d  = bdp_q;
    mask_d = (state_q == PUBLISH) ? '0 : mask_q;
    if (lost_d) mask_d = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (accept && dig == 3'(k)) begin
        buf_d[4*k +: 4] = val;
        bdp_d[k]        = ~pat_q[7];
        mask_d[k]       = 1'b1;
      end
    end

    frame_d = frame_q;
    fdp_d   = fdp_q;
    state_d = COLLECT;
    if (&mask_d) begin
      state_d = PUBLISH;
      frame_d = buf_d;
      fdp_d   = bdp_d;
    end

    pat_err_d = accept && (val == 4'hE);
    sel_err_d = in_vld_q && (n_low >= 4'd2);
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= COLLECT;
      in_vld_q   <= 1'b0;
      sel_q      <= '0;
      pat_q      <= '0;
      prev_sel_q <= '0;
      prev_pat_q <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      bdp_q      <= '0;
      mask_q     <= '0;
      frame_q    <= '0;
      fdp_q      <= '0;
      idle_q     <= '0;
      lost_q     <= 1'b0;
      pat_err_q  <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_vld_q   <= 1'b1;
      sel_q      <= i_digit_sel;
      pat_q      <= i_seg_pat;
      prev_sel_q <= sel_q;
      prev_pat_q <= pat_q;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      bdp_q      <= bdp_d;
      mask_q     <= mask_d;
      frame_q    <= frame_d;
      fdp_q      <= fdp_d;
      idle_q     <= idle_d;
      lost_q     <= lost_d;
      pat_err_q  <= pat_err_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign o_frame       = frame_q;
  assign o_frame_dp    = fdp_q;
  assign o_frame_valid = (state_q == PUBLISH);
  assign o_pat_err     = pat_err_q;
  assign o_sel_err     = sel_err_q;
  assign o_scan_lost   = lost_q;

endmodule
